stream_packer: RTL
==================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 SHALL have parameter DataWidth, default 8, width of one upstream beat (>=1).
REQ-002 SHALL have parameter Ratio, default 4, number of beats packed per output word (>=2).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i (rising edge) and rst_ni.
REQ-004 SHALL have port: clk_i  input  1  clock.
REQ-005 SHALL have port: rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: rok_i  input  1  upstream beat available (reader side of the r/rok stream).
REQ-007 SHALL have port: rdata_i  input  DataWidth  upstream beat data.
REQ-008 SHALL have port: r_o  output  1  beat consumed this cycle when rok_i is also high.
REQ-009 SHALL have port: w_o  output  1  packed word valid (writer side of the w/wok stream).
REQ-010 SHALL have port: wdata_o  output  DataWidth*Ratio  packed word; beat k of the word in bits [k*DataWidth +: DataWidth].
REQ-011 SHALL have port: wok_i  input  1  downstream accepts the word when w_o is also high.

Function
REQ-012 SHALL accept a beat when rok_i && r_o, and transfer a word when w_o && wok_i.
REQ-013 SHALL hold a fill counter cnt in 0..Ratio-1 and a full flag; accepted beat written to lane cnt.
REQ-014 SHALL increment cnt per accepted beat; on the beat into lane Ratio-1, set full and wrap cnt to 0.
REQ-015 SHALL drive w_o = full, registered; no combinational path rok_i -> w_o.
REQ-016 SHALL drive r_o = !full || wok_i; only path wok_i -> r_o is combinational.
REQ-017 SHALL, when full and wok_i and an accepted beat coincide, clear full and write the beat into lane 0 (cnt becomes 1).
REQ-018 SHALL, when Ratio==1 would apply, not be instantiated; Ratio<2 is a static elaboration error.
REQ-019 SHALL keep wdata_o stable while w_o && !wok_i; lanes hold their contents until overwritten.
REQ-020 SHALL sustain one beat per cycle and one word per Ratio cycles with wok_i tied high (no bubbles).
REQ-021 SHALL produce first word with w_o high in the cycle after the Ratio-th beat is accepted (latency 1).
REQ-022 SHALL ignore rdata_i when rok_i is low; r_o may be high with rok_i low, no state change.

Reset
REQ-023 SHALL, with rst_ni low, asynchronously force cnt=0, full=0, all lanes=0.
REQ-024 SHALL, during and after reset, drive w_o=0, wdata_o=0, r_o=1.
REQ-025 SHALL discard any partial word on reset mid-operation; no word emitted for beats before reset.

Configuration
REQ-026 SHALL support macro STREAM_PACKER_FLUSH_EN.
REQ-027 SHALL, with STREAM_PACKER_FLUSH_EN defined, add ports flush_i input 1 and count_o output $clog2(Ratio+1) (beats valid in wdata_o).
REQ-028 SHALL, with flush_i high, !full and cnt>0, set full next cycle with count_o=cnt and cnt=0; lanes >= count_o driven zero on wdata_o.
REQ-029 SHALL, with flush_i high coinciding with an accepted beat, include that beat (count_o=cnt+1, or Ratio if it completes the word).
REQ-030 SHALL ignore flush_i when full, or when cnt==0 and no beat accepted (no empty word).
REQ-031 SHALL drive count_o=Ratio for every non-flushed word and count_o=0 in reset.
REQ-032 SHALL, without STREAM_PACKER_FLUSH_EN, omit flush_i and count_o; only whole words emitted.

Verification (DataWidth=8, Ratio=4)
REQ-033 SHALL cover: reset, then rok_i=1 with beats 0x11,0x22,0x33,0x44, wok_i=1 -> w_o=1 one cycle after 4th beat, wdata_o=0x44332211.
REQ-034 SHALL cover: back-to-back 8 beats 0x01..0x08, wok_i=1 -> words 0x04030201 and 0x08070605, r_o never low.
REQ-035 SHALL cover: word full, wok_i=0 for 3 cycles -> r_o=0, wdata_o stable; wok_i=1 with beat 0xAA -> next cycle w_o=0, lane0=0xAA, cnt=1.
REQ-036 SHALL cover: 2 beats accepted, rst_ni pulsed low mid-cycle -> w_o=0, wdata_o=0, r_o=1 immediately; next 4 beats form a clean word.
REQ-037 SHALL cover (FLUSH_EN): beats 0x55,0x66 then flush_i=1 -> w_o=1, wdata_o=0x00006655, count_o=2; flush_i with cnt=0 -> no word.
REQ-038 SHALL cover (FLUSH_EN): 3rd beat 0x77 with flush_i=1 after 0x55,0x66 -> wdata_o=0x00776655, count_o=3.

Source files
------------

// File: rtl/stream_packer.sv
// stream_packer: packs Ratio upstream beats of DataWidth bits into one
// DataWidth*Ratio word. Beat k of a word lands in wdata_o[k*DataWidth +: DataWidth].
// Upstream uses an r/rok handshake and downstream uses a w/wok handshake.
// One beat per cycle is sustained with wok_i held high.
//
// Optional feature (macro STREAM_PACKER_FLUSH_EN): adds flush_i and count_o.
// A partial word can then be emitted early, and count_o reports how many lanes
// of wdata_o are valid. Unused upper lanes read as zero while the word is
// presented. Without the macro, only whole words are emitted.
module stream_packer #(
  parameter int DataWidth = 8,
  parameter int Ratio     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rok_i,
  input  logic [DataWidth-1:0]         rdata_i,
  output logic                         r_o,
  output logic                         w_o,
  output logic [DataWidth*Ratio-1:0]   wdata_o,
`ifdef STREAM_PACKER_FLUSH_EN
  input  logic                         flush_i,
  output logic [$clog2(Ratio+1)-1:0]   count_o,
`endif
  input  logic                         wok_i
);

  localparam int CntW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int CountW = $clog2(Ratio + 1);
  localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

  // A single-beat "packer" is meaningless; refuse to elaborate it.
  if (Ratio < 2) begin : g_ratio_check
    $error("stream_packer: Ratio must be at least 2");
  end

  logic [CntW-1:0]      r_cnt;
  logic                 r_full;
  logic [DataWidth-1:0] r_lane [Ratio];

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_pop;
  logic [CntW-1:0]      w_cnt_nxt;
  logic                 w_full_nxt;
  logic [DataWidth*Ratio-1:0] w_wdata;

`ifdef STREAM_PACKER_FLUSH_EN
  logic [CountW-1:0]    r_count;
  logic [CountW-1:0]    w_count_nxt;
`endif

  // Ready whenever the output slot is free or is being drained this cycle.
  assign w_ready  = !r_full || wok_i;
  assign w_accept = rok_i && w_ready;
  assign w_pop    = r_full && wok_i;

  assign r_o     = w_ready;
  assign w_o     = r_full;
  assign wdata_o = w_wdata;
`ifdef STREAM_PACKER_FLUSH_EN
  assign count_o = r_count;
`endif

  // Next fill count and full flag from beat acceptance, word drain and flush.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_full_nxt = r_full;
`ifdef STREAM_PACKER_FLUSH_EN
    w_count_nxt = r_count;
`endif
    if (w_pop) begin
      w_full_nxt = 1'b0;
    end else begin
      w_full_nxt = r_full;
    end
    if (w_accept) begin
      if (r_cnt == LastLane) begin
        // The completing beat can only arrive while not full, because cnt
        // is always 0 whenever a word is held.
        w_cnt_nxt  = {CntW{1'b0}};
        w_full_nxt = 1'b1;
`ifdef STREAM_PACKER_FLUSH_EN
        w_count_nxt = CountW'(Ratio);
`endif
      end else begin
        w_cnt_nxt = r_cnt + CntW'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
`ifdef STREAM_PACKER_FLUSH_EN
    // A flush closes the partial word, including a beat arriving this cycle.
    // It is ignored while a word is held or when nothing has been collected.
    if (flush_i && !r_full && (w_accept || (r_cnt != {CntW{1'b0}}))) begin
      w_full_nxt  = 1'b1;
      w_cnt_nxt   = {CntW{1'b0}};
      w_count_nxt = CountW'(r_cnt) + CountW'(w_accept);
    end else begin
      w_count_nxt = w_count_nxt;
    end
`endif
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= {CntW{1'b0}};
      r_full <= 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
      r_count <= {CountW{1'b0}};
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= w_full_nxt;
`ifdef STREAM_PACKER_FLUSH_EN
      r_count <= w_count_nxt;
`endif
    end
  end

  // Lane storage: the accepted beat goes into the lane selected by cnt. Other lanes hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Ratio; k++) begin
        r_lane[k] <= {DataWidth{1'b0}};
      end
    end else begin
      for (int k = 0; k < Ratio; k++) begin
        if (w_accept && (r_cnt == CntW'(k))) begin
          r_lane[k] <= rdata_i;
        end else begin
          r_lane[k] <= r_lane[k];
        end
      end
    end
  end

  // Output word assembly. Lanes beyond count_o are zeroed while a word is presented.
  always_comb begin
    w_wdata = {(DataWidth*Ratio){1'b0}};
    for (int k = 0; k < Ratio; k++) begin
`ifdef STREAM_PACKER_FLUSH_EN
      if (r_full && (CountW'(k) >= r_count)) begin
        w_wdata[k*DataWidth +: DataWidth] = {DataWidth{1'b0}};
      end else begin
        w_wdata[k*DataWidth +: DataWidth] = r_lane[k];
      end
`else
      w_wdata[k*DataWidth +: DataWidth] = r_lane[k];
`endif
    end
  end

endmodule
